// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard/stall handshake between the pipeline datapath and the stall controller.
// master = datapath side (raises hazards, obeys stalls); slave = controller.
interface pipeline_stall_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             conf_LW;
   logic             id_valid;
   logic             id_div;
   logic             id_branch_taken;
   logic             div_done;
   logic             pc_stall;
   logic             if_id_stall;
   logic             id_exe_bubble;
   logic             if_id_flush;
   logic             div_start;
   logic [CNT_W-1:0] stall_cycles;
   logic             hazard_err;

   modport master (
      output conf_LW, id_valid, id_div, id_branch_taken, div_done,
      input  pc_stall, if_id_stall, id_exe_bubble, if_id_flush, div_start,
             stall_cycles, hazard_err
   );

   modport slave (
      input  conf_LW, id_valid, id_div, id_branch_taken, div_done,
      output pc_stall, if_id_stall, id_exe_bubble, if_id_flush, div_start,
             stall_cycles, hazard_err
   );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer: load-use stalls, taken-branch flush, divider
// launch/wait with watchdog, plus a saturating stall counter and sticky error.
module pipeline_stall_ctrl #(
   parameter int DIV_TIMEOUT  = 64,
   parameter int LW_MAX_STALL = 2,
   parameter int CNT_W        = 16
) (
   input logic                  clk,
   input logic                  rst,
   pipeline_stall_ctrl_if.slave bus
);

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      DIV_WAIT = 1'b1
   } state_t;

   localparam logic [7:0] DIV_LAST = 8'(DIV_TIMEOUT - 1);
   localparam logic [3:0] LW_LIMIT = 4'(LW_MAX_STALL);

   state_t           state;
   logic [7:0]       div_cnt;
   logic [3:0]       lw_cnt;
   logic [CNT_W-1:0] stall_cnt;
   logic             hazard_q;

   logic stall;
   logic flush;
   logic start;

   // Outputs are gated by rst so every control line drops the moment reset asserts.
   always_comb begin
      // NOTE: every comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
      stall = 1'b0;
      flush = 1'b0;
      start = 1'b0;
      if (!rst) begin
         case (state)
            RUN: begin
               if (bus.conf_LW) begin
                  stall = 1'b1;
               end else if (bus.id_valid && bus.id_div) begin
                  stall = 1'b1;
                  start = 1'b1;
               end else if (bus.id_valid && bus.id_branch_taken) begin
                  flush = 1'b1;
               end
            end
            DIV_WAIT: stall = !bus.div_done;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= RUN;
         div_cnt   <= '0;
         lw_cnt    <= '0;
         stall_cnt <= '0;
         hazard_q  <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
         if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;

         case (state)
            RUN: begin
               if (bus.conf_LW) begin
                  if (lw_cnt == LW_LIMIT)
                     hazard_q <= 1'b1;
                  if (lw_cnt != 4'hF)
                     lw_cnt <= lw_cnt + 1'b1;
               end else begin
                  lw_cnt <= '0;
                  if (bus.id_valid && bus.id_div) begin
                     state   <= DIV_WAIT;
                     div_cnt <= '0;
                  end
               end
            end
            DIV_WAIT: begin
               lw_cnt <= '0;
               // div_done wins over a coincident watchdog expiry.
               if (bus.div_done) begin
                  state <= RUN;
               end else if (div_cnt == DIV_LAST) begin
                  state    <= RUN;
                  hazard_q <= 1'b1;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

   assign bus.pc_stall      = stall;
   assign bus.if_id_stall   = stall;
   assign bus.id_exe_bubble = stall;
   assign bus.if_id_flush   = flush;
   assign bus.div_start     = start;
   assign bus.stall_cycles  = stall_cnt;
   assign bus.hazard_err    = hazard_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: dut_a uses default parameters,
// dut_b a short watchdog and a 4-bit counter for timeout and saturation cases.
module tb_pipeline_stall_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic conf_LW = 1'b0;
   logic id_valid = 1'b0;
   logic id_div = 1'b0;
   logic id_branch_taken = 1'b0;
   logic div_done = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipeline_stall_ctrl_if #(.CNT_W(16)) if_a ();
   pipeline_stall_ctrl_if #(.CNT_W(4))  if_b ();

   assign if_a.conf_LW         = conf_LW;
   assign if_a.id_valid        = id_valid;
   assign if_a.id_div          = id_div;
   assign if_a.id_branch_taken = id_branch_taken;
   assign if_a.div_done        = div_done;
   assign if_b.conf_LW         = conf_LW;
   assign if_b.id_valid        = id_valid;
   assign if_b.id_div          = id_div;
   assign if_b.id_branch_taken = id_branch_taken;
   assign if_b.div_done        = div_done;

   pipeline_stall_ctrl #(.DIV_TIMEOUT(64), .LW_MAX_STALL(2), .CNT_W(16)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (if_a.slave)
   );

   pipeline_stall_ctrl #(.DIV_TIMEOUT(4), .LW_MAX_STALL(2), .CNT_W(4)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (if_b.slave)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Drive one cycle of inputs just after the falling edge, then settle 1 time unit.
   task automatic apply(input logic c, input logic v, input logic d, input logic b, input logic dd);
      @(negedge clk);
      conf_LW         = c;
      id_valid        = v;
      id_div          = d;
      id_branch_taken = b;
      div_done        = dd;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      conf_LW = 1'b0; id_valid = 1'b0; id_div = 1'b0; id_branch_taken = 1'b0; div_done = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      // Reset state: combinational outputs gated low even with a hazard present.
      conf_LW = 1'b1;
      #1;
      check("rst_gates_stall", 32'(if_a.pc_stall), 32'd0);
      check("rst_stall_cycles", 32'(if_a.stall_cycles), 32'd0);
      check("rst_hazard_err", 32'(if_a.hazard_err), 32'd0);
      conf_LW = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // Load-use stall for exactly two cycles.
      apply(1, 0, 0, 0, 0);
      check("lw2_c1_pc_stall", 32'(if_a.pc_stall), 32'd1);
      check("lw2_c1_if_id_stall", 32'(if_a.if_id_stall), 32'd1);
      check("lw2_c1_bubble", 32'(if_a.id_exe_bubble), 32'd1);
      check("lw2_c1_flush", 32'(if_a.if_id_flush), 32'd0);
      apply(1, 0, 0, 0, 0);
      check("lw2_c2_pc_stall", 32'(if_a.pc_stall), 32'd1);
      apply(0, 0, 0, 0, 0);
      check("lw2_release", 32'(if_a.pc_stall), 32'd0);
      check("lw2_stall_cycles", 32'(if_a.stall_cycles), 32'd2);
      check("lw2_no_err", 32'(if_a.hazard_err), 32'd0);

      // Load-use overrun: third consecutive stall trips the sticky error.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         apply(1, 0, 0, 0, 0);
         check("lw3_stall", 32'(if_a.pc_stall), 32'd1);
      end
      check("lw3_err_before_edge3", 32'(if_a.hazard_err), 32'd0);
      apply(0, 0, 0, 0, 0);
      check("lw3_err_set", 32'(if_a.hazard_err), 32'd1);
      check("lw3_stall_cycles", 32'(if_a.stall_cycles), 32'd3);
      apply(0, 0, 0, 0, 0);
      check("lw3_err_sticky", 32'(if_a.hazard_err), 32'd1);

      // Divider issue with a coincident taken branch, done after 5 wait cycles.
      do_reset();
      apply(0, 1, 1, 1, 0);
      check("div_start_pulse", 32'(if_a.div_start), 32'd1);
      check("div_issue_no_flush", 32'(if_a.if_id_flush), 32'd0);
      check("div_issue_stall", 32'(if_a.pc_stall), 32'd1);
      apply(1, 1, 0, 1, 0);
      check("div_wait_ignores_lw_br", {31'd0, if_a.if_id_flush}, 32'd0);
      check("div_wait_start_low", 32'(if_a.div_start), 32'd0);
      check("div_wait_stall1", 32'(if_a.pc_stall), 32'd1);
      for (int i = 0; i < 4; i++) begin
         apply(0, 0, 0, 0, 0);
         check("div_wait_stall", 32'(if_a.pc_stall), 32'd1);
      end
      apply(0, 0, 0, 0, 1);
      check("div_done_release", 32'(if_a.pc_stall), 32'd0);
      check("div_done_bubble", 32'(if_a.id_exe_bubble), 32'd0);
      apply(0, 0, 0, 0, 0);
      check("div_stall_cycles", 32'(if_a.stall_cycles), 32'd6);
      check("div_no_err", 32'(if_a.hazard_err), 32'd0);

      // Watchdog: DIV_TIMEOUT=4, no div_done.
      do_reset();
      apply(0, 1, 1, 0, 0);
      check("to_issue_start", 32'(if_b.div_start), 32'd1);
      for (int i = 0; i < 4; i++) begin
         apply(0, 0, 0, 0, 0);
         check("to_wait_stall", 32'(if_b.pc_stall), 32'd1);
      end
      apply(0, 0, 0, 0, 0);
      check("to_released", 32'(if_b.pc_stall), 32'd0);
      check("to_err", 32'(if_b.hazard_err), 32'd1);
      check("to_stall_cycles", 32'(if_b.stall_cycles), 32'd5);
      apply(0, 0, 0, 0, 1);
      check("run_done_no_stall", 32'(if_b.pc_stall), 32'd0);
      check("run_done_no_start", 32'(if_b.div_start), 32'd0);
      check("run_done_no_flush", 32'(if_b.if_id_flush), 32'd0);
      apply(0, 0, 0, 0, 0);
      check("run_done_cnt_same", 32'(if_b.stall_cycles), 32'd5);

      // div_done coinciding with watchdog expiry counts as done, no error.
      do_reset();
      apply(0, 1, 1, 0, 0);
      for (int i = 0; i < 3; i++) apply(0, 0, 0, 0, 0);
      apply(0, 0, 0, 0, 1);
      check("edge_done_release", 32'(if_b.pc_stall), 32'd0);
      apply(0, 0, 0, 0, 0);
      check("edge_done_no_err", 32'(if_b.hazard_err), 32'd0);
      check("edge_done_cycles", 32'(if_b.stall_cycles), 32'd4);

      // Taken branch under load-use: stall only, then flush once operands are valid.
      do_reset();
      apply(1, 1, 0, 1, 0);
      check("br_lw_no_flush", 32'(if_a.if_id_flush), 32'd0);
      check("br_lw_stall", 32'(if_a.pc_stall), 32'd1);
      apply(0, 1, 0, 1, 0);
      check("br_flush", 32'(if_a.if_id_flush), 32'd1);
      check("br_flush_no_stall", 32'(if_a.pc_stall), 32'd0);
      apply(0, 0, 0, 0, 0);
      check("br_flush_drop", 32'(if_a.if_id_flush), 32'd0);
      apply(0, 0, 0, 1, 0);
      check("br_invalid_ignored", 32'(if_a.if_id_flush), 32'd0);

      // Asynchronous reset in the middle of DIV_WAIT.
      do_reset();
      apply(0, 1, 1, 0, 0);
      apply(0, 0, 0, 0, 0);
      check("arst_pre_stall", 32'(if_a.pc_stall), 32'd1);
      check("arst_pre_cnt", 32'(if_a.stall_cycles), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_stall_low", 32'(if_a.pc_stall), 32'd0);
      check("arst_bubble_low", 32'(if_a.id_exe_bubble), 32'd0);
      check("arst_cnt_zero", 32'(if_a.stall_cycles), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("arst_back_in_run", 32'(if_a.pc_stall), 32'd0);

      // Saturation on the 4-bit counter: reach 0xE, then three more stall cycles.
      do_reset();
      for (int i = 0; i < 14; i++) apply(1, 0, 0, 0, 0);
      apply(1, 0, 0, 0, 0);
      check("sat_at_e", 32'(if_b.stall_cycles), 32'd14);
      apply(1, 0, 0, 0, 0);
      apply(1, 0, 0, 0, 0);
      apply(0, 0, 0, 0, 0);
      check("sat_at_f", 32'(if_b.stall_cycles), 32'd15);
      check("sat_wide_cnt", 32'(if_a.stall_cycles), 32'd17);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage dynamic pipeline.
- Consumes the load-use conflict flag from the forwarding logic, the ID-stage branch decision and the multi-cycle divider handshake.
- Produces PC/IF-ID hold, ID-EXE bubble insertion, IF-ID flush and the divider start pulse.
- Also keeps a saturating stall-cycle counter and a sticky hazard error flag for debug.

Parameters:
- DIV_TIMEOUT, 64: max cycles spent in DIV_WAIT before watchdog abort; legal range 2..255.
- LW_MAX_STALL, 2: max consecutive load-use stall cycles before hazard_err is set; legal range 1..15.
- CNT_W, 16: width of stall_cycles.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- conf_LW  input  1  load-use conflict from forwarding logic (combinational, same cycle).
- id_valid  input  1  ID stage holds a valid instruction.
- id_div  input  1  ID instruction is DIV/DIVU.
- id_branch_taken  input  1  ID branch/jump resolved taken.
- div_done  input  1  divider result valid (single-cycle pulse).
- pc_stall  output  1  hold PC.
- if_id_stall  output  1  hold IF/ID register.
- id_exe_bubble  output  1  load NOP into ID/EXE.
- if_id_flush  output  1  clear IF/ID (squash wrong-path fetch).
- div_start  output  1  one-cycle divider launch.
- stall_cycles  output  CNT_W  saturating count of cycles with pc_stall=1.
- hazard_err  output  1  sticky error: LW stall overrun or divider timeout.

Behaviour:
- States: RUN, DIV_WAIT. Counters: div_cnt (8 bit), lw_cnt (4 bit).
- Reset (async):
  - state=RUN; div_cnt=0; lw_cnt=0; stall_cycles=0; hazard_err=0.
  - All combinational outputs evaluate to 0 while rst=1.
- RUN, conf_LW=1:
  - pc_stall=if_id_stall=id_exe_bubble=1; if_id_flush=0; div_start=0.
  - lw_cnt increments, saturating at 15.
  - If lw_cnt already equals LW_MAX_STALL in this cycle, set hazard_err at the next edge.
- RUN, conf_LW=0: lw_cnt cleared to 0 at the next edge.
- RUN, conf_LW=0, id_valid=1, id_div=1:
  - div_start=1, pc_stall=if_id_stall=id_exe_bubble=1.
  - Next state DIV_WAIT, div_cnt=0.
  - id_branch_taken is ignored this cycle; div has priority and no flush occurs.
- RUN, conf_LW=0, id_valid=1, id_div=0, id_branch_taken=1:
  - if_id_flush=1, no stall.
  - id_branch_taken with conf_LW=1 never flushes; operands are not yet valid.
- RUN, id_valid=0: id_div and id_branch_taken are ignored.
- DIV_WAIT, div_done=0:
  - pc_stall=if_id_stall=id_exe_bubble=1; div_start=0; conf_LW and id_branch_taken are ignored.
  - div_cnt increments.
  - If div_cnt==DIV_TIMEOUT-1: next state RUN, hazard_err set, stall released next cycle.
- DIV_WAIT, div_done=1:
  - All stall outputs 0 this cycle, so DIV advances to EXE and captures the result.
  - Next state RUN. div_done and timeout in the same cycle count as done, with no error.
- div_done while in RUN is ignored.
- stall_cycles: +1 at each edge where pc_stall=1; saturates at all-ones, no wrap.
- hazard_err: sticky until rst.
- Reset mid-DIV_WAIT: return to RUN immediately and release all stalls asynchronously.
- Output timing:
  - All outputs except stall_cycles/hazard_err are combinational from state and inputs (zero latency).
  - stall_cycles/hazard_err are registered.

Test Plan:
- Reset, then conf_LW=1 for 2 cycles -> pc_stall/if_id_stall/id_exe_bubble high exactly 2 cycles, stall_cycles=2, hazard_err=0.
- conf_LW held 3 cycles with LW_MAX_STALL=2 -> stall all 3 cycles, hazard_err=1 after 3rd edge, stays 1 after conf_LW drops.
- id_valid=1,id_div=1,id_branch_taken=1 -> div_start pulse 1 cycle, if_id_flush=0, state DIV_WAIT. div_done after 5 cycles -> stall high 6 cycles total, drops in div_done cycle, stall_cycles=6.
- DIV_TIMEOUT=4, div_done never -> stall 1 issue cycle + 4 wait cycles, then RUN, hazard_err=1. A later div_done pulse in RUN -> no output change.
- id_branch_taken=1 with conf_LW=1 -> no flush, stall only; next cycle conf_LW=0 with branch still taken -> if_id_flush=1 for one cycle.
- Assert rst mid-DIV_WAIT -> outputs 0 without a clock edge, stall_cycles=0. stall_cycles forced to 0xFFFE then 3 stall cycles -> reads 0xFFFF.
